// File: rtl/fetch_stage_if.sv
// Signal bundle between the IF stage and its neighbours: D-stage redirects,
// CP0 control, instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if;
    logic        stall;
    logic        pc_branch;
    logic [31:0] B_addr;
    logic        jump;
    logic [31:0] J_addr;
    logic        jr;
    logic [31:0] JR_addr;
    logic        d_is_ctrl;
    logic        exc_req;
    logic        eret;
    logic [31:0] EPC;
    logic [31:0] im_data;
    logic [31:0] pc_f;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic        BD_D;
    logic        ExcValid_D;
    logic [4:0]  ExcCode_D;

    // Master is the environment (D stage, CP0, IM); slave is the fetch stage.
    modport master (
        output stall, pc_branch, B_addr, jump, J_addr, jr, JR_addr, d_is_ctrl,
        output exc_req, eret, EPC, im_data,
        input  pc_f, IR_D, PC_D, PC4_D, BD_D, ExcValid_D, ExcCode_D
    );

    modport slave (
        input  stall, pc_branch, B_addr, jump, J_addr, jr, JR_addr, d_is_ctrl,
        input  exc_req, eret, EPC, im_data,
        output pc_f, IR_D, PC_D, PC4_D, BD_D, ExcValid_D, ExcCode_D
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register with prioritised next-PC selection, fetch-address
// checking, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.slave     bus
);
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] ir_q,    ir_d;
    logic [31:0] pcd_q,   pcd_d;
    logic [31:0] pc4d_q,  pc4d_d;
    logic        bd_q,    bd_d;
    logic        excv_q,  excv_d;
    logic [4:0]  excc_q,  excc_d;

    logic [31:0] pc_plus4;
    logic        fetch_bad;

    assign pc_plus4  = pc_q + 32'd4;
    assign fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

    always_comb begin
        pc_d   = pc_plus4;
        ir_d   = fetch_bad ? 32'h0 : bus.im_data;
        pcd_d  = pc_q;
        pc4d_d = pc_plus4;
        bd_d   = bus.d_is_ctrl;
        excv_d = fetch_bad;
        excc_d = fetch_bad ? EXC_ADEL : 5'd0;

        if (bus.exc_req) begin
            // Flush to nop but keep the interrupted PC visible in IF/ID.
            pc_d   = EXC_ENTRY;
            ir_d   = 32'h0;
            bd_d   = 1'b0;
            excv_d = 1'b0;
            excc_d = 5'd0;
        end else if (bus.eret) begin
            pc_d   = bus.EPC;
            ir_d   = 32'h0;
            pcd_d  = RESET_PC;
            pc4d_d = RESET_PC + 32'd4;
            bd_d   = 1'b0;
            excv_d = 1'b0;
            excc_d = 5'd0;
        end else if (bus.stall) begin
            pc_d   = pc_q;
            ir_d   = ir_q;
            pcd_d  = pcd_q;
            pc4d_d = pc4d_q;
            bd_d   = bd_q;
            excv_d = excv_q;
            excc_d = excc_q;
        end else if (bus.jr) begin
            pc_d = bus.JR_addr;
        end else if (bus.jump) begin
            pc_d = bus.J_addr;
        end else if (bus.pc_branch) begin
            pc_d = bus.B_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ir_q   <= 32'h0;
            pcd_q  <= RESET_PC;
            pc4d_q <= RESET_PC + 32'd4;
            bd_q   <= 1'b0;
            excv_q <= 1'b0;
            excc_q <= 5'd0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            pcd_q  <= pcd_d;
            pc4d_q <= pc4d_d;
            bd_q   <= bd_d;
            excv_q <= excv_d;
            excc_q <= excc_d;
        end
    end

    assign bus.pc_f       = pc_q;
    assign bus.IR_D       = ir_q;
    assign bus.PC_D       = pcd_q;
    assign bus.PC4_D      = pc4d_q;
    assign bus.BD_D       = bd_q;
    assign bus.ExcValid_D = excv_q;
    assign bus.ExcCode_D  = excc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, branch delay slot, stalled jump,
// fetch-address exceptions at both range edges, exception/eret entry.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word at address a is 3C01_0000 + (a-3000)/4 + 1.
    assign bus.im_data = 32'h3C01_0000 + ((bus.pc_f - 32'h3000) >> 2) + 32'd1;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.pc_branch = 0; bus.B_addr = 0; bus.jump = 0; bus.J_addr = 0;
        bus.jr = 0; bus.JR_addr = 0; bus.d_is_ctrl = 0; bus.exc_req = 0; bus.eret = 0;
        bus.EPC = 0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        check32("rst_pc_f", bus.pc_f, 32'h3000);
        check32("rst_ir", bus.IR_D, 32'h0);
        check32("rst_bd", 32'(bus.BD_D), 32'h0);
        check32("rst_pcd", bus.PC_D, 32'h3000);
        check32("rst_pc4d", bus.PC4_D, 32'h3004);
        check32("rst_excv", 32'(bus.ExcValid_D), 32'h0);
        check32("rst_excc", 32'(bus.ExcCode_D), 32'h0);

        reset = 0;
        tick();
        check32("seq1_pc_f", bus.pc_f, 32'h3004);
        check32("seq1_ir", bus.IR_D, 32'h3C01_0001);
        check32("seq1_pcd", bus.PC_D, 32'h3000);
        tick();
        check32("seq2_pc_f", bus.pc_f, 32'h3008);
        check32("seq2_ir", bus.IR_D, 32'h3C01_0002);

        // Taken branch: the delay slot at 3008 still enters IF/ID.
        bus.pc_branch = 1; bus.B_addr = 32'h3020; bus.d_is_ctrl = 1;
        tick();
        check32("br_pc_f", bus.pc_f, 32'h3020);
        check32("br_ir", bus.IR_D, 32'h3C01_0003);
        check32("br_bd", 32'(bus.BD_D), 32'h1);
        check32("br_pcd", bus.PC_D, 32'h3008);
        check32("br_pc4d", bus.PC4_D, 32'h300C);

        idle_inputs();
        bus.jump = 1; bus.J_addr = 32'h3010;
        tick();
        check32("j_pc_f", bus.pc_f, 32'h3010);
        check32("j_ir", bus.IR_D, 32'h3C01_0009);
        check32("j_bd", 32'(bus.BD_D), 32'h0);

        // Stall with jump pending: everything holds, jump ignored.
        bus.stall = 1; bus.J_addr = 32'h3100; bus.d_is_ctrl = 1;
        tick();
        check32("st1_pc_f", bus.pc_f, 32'h3010);
        check32("st1_ir", bus.IR_D, 32'h3C01_0009);
        check32("st1_bd", 32'(bus.BD_D), 32'h0);
        tick();
        check32("st2_pc_f", bus.pc_f, 32'h3010);
        check32("st2_ir", bus.IR_D, 32'h3C01_0009);
        bus.stall = 0;
        tick();
        check32("st3_pc_f", bus.pc_f, 32'h3100);
        check32("st3_ir", bus.IR_D, 32'h3C01_0005);
        check32("st3_bd", 32'(bus.BD_D), 32'h1);

        idle_inputs();
        bus.jr = 1; bus.JR_addr = 32'h3002;
        tick();
        check32("jrm_pc_f", bus.pc_f, 32'h3002);
        check32("jrm_ir", bus.IR_D, 32'h3C01_0041);
        idle_inputs();
        tick();
        check32("mis_pc_f", bus.pc_f, 32'h3006);
        check32("mis_ir", bus.IR_D, 32'h0);
        check32("mis_excv", 32'(bus.ExcValid_D), 32'h1);
        check32("mis_excc", 32'(bus.ExcCode_D), 32'h4);
        check32("mis_pcd", bus.PC_D, 32'h3002);

        bus.jr = 1; bus.JR_addr = 32'h0000_1000;
        tick();
        check32("jro_pc_f", bus.pc_f, 32'h1000);
        idle_inputs();
        tick();
        check32("low_ir", bus.IR_D, 32'h0);
        check32("low_excv", 32'(bus.ExcValid_D), 32'h1);
        check32("low_excc", 32'(bus.ExcCode_D), 32'h4);
        check32("low_pcd", bus.PC_D, 32'h1000);

        // Upper boundary: 6FFC legal, 7000 faults.
        bus.jr = 1; bus.JR_addr = 32'h6FFC;
        tick();
        idle_inputs();
        tick();
        check32("hi_pc_f", bus.pc_f, 32'h7000);
        check32("hi_ir", bus.IR_D, 32'h3C01_1000);
        check32("hi_excv", 32'(bus.ExcValid_D), 32'h0);
        check32("hi_pcd", bus.PC_D, 32'h6FFC);
        tick();
        check32("ovr_excv", 32'(bus.ExcValid_D), 32'h1);
        check32("ovr_pcd", bus.PC_D, 32'h7000);

        bus.exc_req = 1; bus.eret = 1; bus.stall = 1; bus.d_is_ctrl = 1; bus.EPC = 32'h3024;
        tick();
        check32("exc_pc_f", bus.pc_f, 32'h4180);
        check32("exc_ir", bus.IR_D, 32'h0);
        check32("exc_bd", 32'(bus.BD_D), 32'h0);
        check32("exc_excv", 32'(bus.ExcValid_D), 32'h0);
        check32("exc_pcd", bus.PC_D, 32'h7004);
        check32("exc_pc4d", bus.PC4_D, 32'h7008);
        idle_inputs();
        tick();
        check32("h_pc_f", bus.pc_f, 32'h4184);
        check32("h_ir", bus.IR_D, 32'h3C01_0461);

        bus.eret = 1; bus.EPC = 32'h3024; bus.stall = 1; bus.d_is_ctrl = 1;
        tick();
        check32("eret_pc_f", bus.pc_f, 32'h3024);
        check32("eret_ir", bus.IR_D, 32'h0);
        check32("eret_bd", 32'(bus.BD_D), 32'h0);
        check32("eret_excv", 32'(bus.ExcValid_D), 32'h0);
        idle_inputs();
        tick();
        check32("ret_pc_f", bus.pc_f, 32'h3028);
        check32("ret_ir", bus.IR_D, 32'h3C01_000A);

        // Reset overrides a simultaneous redirect and exception.
        reset = 1; bus.jump = 1; bus.J_addr = 32'h3100; bus.exc_req = 1;
        tick();
        check32("rst2_pc_f", bus.pc_f, 32'h3000);
        check32("rst2_pcd", bus.PC_D, 32'h3000);
        check32("rst2_ir", bus.IR_D, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; sits directly downstream of the decode-stage branch unit and consumes its pc_branch, B_addr and J_addr.
- Holds the PC register and selects the next PC from sequential, branch, jump, jump-register, exception-entry and eret sources.
- Drives the instruction-memory address.
- Owns the IF/ID pipeline register: instruction, PC, PC+4, branch-delay-slot flag and fetch-exception code for the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; hold PC and IF/ID.
- pc_branch  input  1  taken conditional branch from the D stage.
- B_addr  input  32  branch target from the D stage.
- jump  input  1  j/jal in the D stage.
- J_addr  input  32  jump target from the D stage.
- jr  input  1  jr/jalr in the D stage.
- JR_addr  input  32  forwarded register target.
- d_is_ctrl  input  1  D-stage instruction is any branch or jump; the instruction now in F is its delay slot.
- exc_req  input  1  CP0 requests exception entry.
- eret  input  1  eret committed.
- EPC  input  32  return address from CP0.
- im_data  input  32  instruction word read combinationally at pc_f.
- pc_f  output  32  current fetch PC, driven to the IM address.
- IR_D  output  32  IF/ID instruction.
- PC_D  output  32  IF/ID PC.
- PC4_D  output  32  IF/ID PC+4.
- BD_D  output  1  IF/ID delay-slot flag.
- ExcValid_D  output  1  IF/ID fetch exception present.
- ExcCode_D  output  5  IF/ID exception code.

Behaviour:
- Reset (sync, highest priority):
  - pc_f = RESET_PC.
  - IR_D = 0 (nop), PC_D = RESET_PC, PC4_D = RESET_PC+4.
  - BD_D = 0, ExcValid_D = 0, ExcCode_D = 0.
- Next-PC priority, evaluated each posedge:
  - reset > exc_req > eret > stall > jr > jump > pc_branch > pc_f+4.
  - At most one of jr/jump/pc_branch is asserted by construction. If several are asserted anyway, the priority order still applies.
- exc_req: pc_f <= EXC_ENTRY; IF/ID flushed to the reset-nop contents, except PC_D = pc_f and PC4_D = pc_f+4. Overrides stall.
- eret: pc_f <= EPC; IF/ID flushed to nop. eret has no delay slot. Overrides stall.
- stall (no exc_req/eret): pc_f and all IF/ID outputs hold. Redirect inputs are ignored, because the stalled D instruction re-presents them next cycle.
- Redirect (jr/jump/pc_branch, no stall): pc_f <= target. The instruction currently fetched (the delay slot) is NOT flushed; it latches into IF/ID normally with BD_D = 1.
- Normal latch into IF/ID:
  - PC_D <= pc_f, PC4_D <= pc_f+4, BD_D <= d_is_ctrl.
  - Fetch legal: IR_D <= im_data, ExcValid_D <= 0, ExcCode_D <= 0.
- Fetch-address exception:
  - Condition: pc_f[1:0] != 0, or pc_f < IM_LO, or pc_f > IM_HI.
  - IR_D <= 0, ExcValid_D <= 1, ExcCode_D <= 5'd4 (AdEL).
  - PC_D still records the faulting pc_f. The PC keeps advancing per the normal rules until exc_req arrives.
- Arithmetic: all adds are 32-bit unsigned and wrap modulo 2^32; no carry out.
- Latency:
  - A redirect seen in cycle n sets pc_f in cycle n+1.
  - An instruction fetched in cycle n appears on IR_D in cycle n+1.
- Simultaneous events:
  - exc_req + eret: exc_req wins.
  - exc_req + stall: the exception is taken and the stall is dropped.
  - reset during a stall, redirect or exception: reset wins in that cycle.
- pc_f is a pure register output; it has no combinational path from the inputs.

Test Plan:
- Reset: assert reset 2 cycles, im_data = 32'h3C01_0001 -> pc_f = 32'h3000, IR_D = 0, BD_D = 0. After release: 32'h3004, 32'h3008 on successive cycles; IR_D = 32'h3C01_0001 with PC_D = 32'h3000.
- Branch with delay slot: at pc_f = 32'h3008 drive pc_branch = 1, B_addr = 32'h3020, d_is_ctrl = 1 -> next pc_f = 32'h3020; IR_D = word fetched at 32'h3008, BD_D = 1, PC_D = 32'h3008.
- Stall with redirect: pc_f = 32'h3010, stall = 1 and jump = 1 with J_addr = 32'h3100 for 2 cycles -> pc_f stays 32'h3010 and IR_D is unchanged. Then stall = 0 with jump held -> pc_f = 32'h3100.
- jr to misaligned address: jr = 1, JR_addr = 32'h3002 -> pc_f = 32'h3002. Next cycle IR_D = 0, ExcValid_D = 1, ExcCode_D = 4, PC_D = 32'h3002.
- jr out of range: jr = 1, JR_addr = 32'h0000_1000 -> next cycle ExcValid_D = 1, ExcCode_D = 4, IR_D = 0.
- Exception vs eret/stall: exc_req = 1, eret = 1, stall = 1 together -> pc_f = 32'h4180, IR_D = 0, BD_D = 0. Later eret = 1 with EPC = 32'h3024 -> pc_f = 32'h3024 and IF/ID flushed.
